// File: rtl/d8_pipe_sched_pkg.sv
// rtl/d8_pipe_sched_pkg.sv - d8 opcode set and issue-class helpers
package d8_pipe_sched_pkg;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_ADD = 8'h01;
    localparam logic [7:0] OP_SOU = 8'h02;
    localparam logic [7:0] OP_SHL = 8'h03;
    localparam logic [7:0] OP_SHR = 8'h04;
    localparam logic [7:0] OP_COP = 8'h05;
    localparam logic [7:0] OP_AFC = 8'h06;
    localparam logic [7:0] OP_LOD = 8'h07;
    localparam logic [7:0] OP_STR = 8'h08;
    localparam logic [7:0] OP_JMP = 8'h09;
    localparam logic [7:0] OP_JMZ = 8'h0A;
    localparam logic [7:0] OP_VWR = 8'h0B;

    typedef struct packed {
        logic rd_bc;
        logic rd_b;
        logic wr_a;
    } op_class_t;

    // Reads both source operands b and c
    function automatic logic is_rd_bc(input logic [7:0] op);
        return (op == OP_ADD) || (op == OP_SOU) || (op == OP_SHL) ||
               (op == OP_SHR) || (op == OP_VWR);
    endfunction

    // Reads source operand b only
    function automatic logic is_rd_b(input logic [7:0] op);
        return (op == OP_COP) || (op == OP_STR) || (op == OP_JMZ) || (op == OP_JMP);
    endfunction

    // Writes destination register a
    function automatic logic is_wr_a(input logic [7:0] op);
        return (op == OP_ADD) || (op == OP_SOU) || (op == OP_SHL) || (op == OP_SHR) ||
               (op == OP_COP) || (op == OP_AFC) || (op == OP_LOD);
    endfunction

    function automatic op_class_t op_class(input logic [7:0] op);
        op_class_t cls;
        cls.rd_bc = is_rd_bc(op);
        cls.rd_b  = is_rd_b(op);
        cls.wr_a  = is_wr_a(op);
        return cls;
    endfunction

endpackage

// File: rtl/d8_pipe_sched_scoreboard.sv
// rtl/d8_pipe_sched_scoreboard.sv - per-register write-pending countdown scoreboard
module d8_sched_scoreboard
    import d8_pipe_sched_pkg::*;
#(
    parameter int REG_AW = 4,
    parameter int WB_LAT = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_hold,
    input  logic              i_set,
    input  logic [REG_AW-1:0] i_set_idx,
    input  logic [REG_AW-1:0] i_rd_b_idx,
    input  logic [REG_AW-1:0] i_rd_c_idx,
    output logic              o_pend_b_nz,
    output logic              o_pend_c_nz,
    output logic              o_busy
);

    localparam int         NREG = 2 ** REG_AW;
    localparam logic [1:0] LAT  = 2'(WB_LAT);

    logic [1:0] r_pend [NREG];
    logic       w_busy;

    // Countdowns tick only while the pipe moves; a new writer reloads its entry over the tick
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NREG; i++) r_pend[i] <= 2'd0;
        end else if (!i_hold) begin
            for (int i = 0; i < NREG; i++) begin
                if (i_set && (i_set_idx == REG_AW'(i))) r_pend[i] <= LAT;
                else if (r_pend[i] != 2'd0)            r_pend[i] <= r_pend[i] - 2'd1;
            end
        end
    end

    // Any entry still counting means a write is in flight
    always_comb begin
        w_busy = 1'b0;
        for (int i = 0; i < NREG; i++) w_busy = w_busy | (r_pend[i] != 2'd0);
    end

    assign o_pend_b_nz = (r_pend[i_rd_b_idx] != 2'd0);
    assign o_pend_c_nz = (r_pend[i_rd_c_idx] != 2'd0);
    assign o_busy      = w_busy;

endmodule

// File: rtl/d8_pipe_sched.sv
// rtl/d8_pipe_sched.sv - RAW-hazard issue scheduler between LI/DI and DI/EX
module d8_pipe_sched
    import d8_pipe_sched_pkg::*;
#(
    parameter int REG_AW = 4,
    parameter int WB_LAT = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  li_di_op,
    input  logic [7:0]  li_di_a,
    input  logic [7:0]  li_di_b,
    input  logic [7:0]  li_di_c,
    input  logic        hold,
    input  logic        flush,
    input  logic        cnt_clr,
    output logic [7:0]  li_di_op_out,
    output logic        en,
    output logic [15:0] stall_cnt,
    output logic        busy
);

    op_class_t   w_cls;
    logic        w_pend_b_nz;
    logic        w_pend_c_nz;
    logic        w_hazard;
    logic        w_issue;
    logic        w_count;
    logic [15:0] w_stall_cnt_nxt;
    logic [15:0] r_stall_cnt;
    logic        w_unused_hi;

    assign w_cls    = op_class(li_di_op);
    assign w_hazard = ((w_cls.rd_bc | w_cls.rd_b) & w_pend_b_nz) | (w_cls.rd_bc & w_pend_c_nz);
    assign w_issue  = !sys_rst && !flush && !hold && !w_hazard;
    assign w_count  = w_hazard && !hold && !flush;

    // Register indices ignore the upper operand bits
    assign w_unused_hi = ^{li_di_a[7:REG_AW], li_di_b[7:REG_AW], li_di_c[7:REG_AW]};

    d8_sched_scoreboard #(
        .REG_AW (REG_AW),
        .WB_LAT (WB_LAT)
    ) u_scoreboard (
        .i_clk       (sys_clk),
        .i_rst       (sys_rst),
        .i_hold      (hold),
        .i_set       (w_issue && w_cls.wr_a),
        .i_set_idx   (li_di_a[REG_AW-1:0]),
        .i_rd_b_idx  (li_di_b[REG_AW-1:0]),
        .i_rd_c_idx  (li_di_c[REG_AW-1:0]),
        .o_pend_b_nz (w_pend_b_nz),
        .o_pend_c_nz (w_pend_c_nz),
        .o_busy      (busy)
    );

    // Priority mux: reset, then flush (advance with bubble), hold, hazard, else issue
    always_comb begin
        en           = 1'b0;
        li_di_op_out = OP_NOP;
        if (sys_rst) begin
            en = 1'b0;
        end else if (flush) begin
            en = 1'b1;
        end else if (hold || w_hazard) begin
            en = 1'b0;
        end else begin
            en           = 1'b1;
            li_di_op_out = li_di_op;
        end
    end

    // Next stall count: clear wins, otherwise saturating increment on counted stalls
    always_comb begin
        w_stall_cnt_nxt = r_stall_cnt;
        if (cnt_clr)                                 w_stall_cnt_nxt = 16'd0;
        else if (w_count && r_stall_cnt != 16'hFFFF) w_stall_cnt_nxt = r_stall_cnt + 16'd1;
    end

    // Stall counter register
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) r_stall_cnt <= 16'd0;
        else         r_stall_cnt <= w_stall_cnt_nxt;
    end

    assign stall_cnt = r_stall_cnt;

endmodule
